// File: rtl/accel_tilt_quantizer.sv
// accel_tilt_quantizer
// Averages windows of 2^WINDOW_LOG2 accelerometer samples and turns the X/Y
// averages into steer/throttle codes with enter/exit hysteresis.
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous, active-high reset
//   sample_valid - one-cycle strobe, acl_data holds a new sample
//   acl_data     - {X[14:10], Y[9:5], Z[4:0]}, 5-bit two's complement, Z unused
//   out_valid    - code_out holds a new, unconsumed decision
//   out_ready    - consumer accepts code_out this cycle
//   code_out     - {28'b0, throttle[1:0], steer[1:0]}
//   overrun_cnt  - saturating count of dropped samples
module accel_tilt_quantizer #(
   parameter int unsigned WINDOW_LOG2 = 3,
   parameter int          ENTER_TH    = 4,
   parameter int          EXIT_TH     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sample_valid,
   input  logic [14:0] acl_data,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] code_out,
   output logic [7:0]  overrun_cnt
);

   localparam int unsigned AW = 5 + WINDOW_LOG2;
   localparam int unsigned CW = WINDOW_LOG2 + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'((1 << WINDOW_LOG2) - 1);
   localparam logic signed [AW-1:0] ENTER_P = AW'(ENTER_TH);
   localparam logic signed [AW-1:0] ENTER_N = AW'(-ENTER_TH);
   localparam logic signed [AW-1:0] EXIT_P  = AW'(EXIT_TH);
   localparam logic signed [AW-1:0] EXIT_N  = AW'(-EXIT_TH);

   localparam logic [1:0] STEER_LEFT  = 2'b01;
   localparam logic [1:0] STEER_RIGHT = 2'b10;
   localparam logic [1:0] THR_ACCEL   = 2'b01;
   localparam logic [1:0] THR_BRAKE   = 2'b10;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      EVAL  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                state, state_nx;
   logic signed [AW-1:0]  sum_x, sum_x_nx;
   logic signed [AW-1:0]  sum_y, sum_y_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic [1:0]            steer, steer_nx;
   logic [1:0]            throttle, throttle_nx;
   logic                  out_valid_nx;
   logic [7:0]            overrun_nx;
   logic                  drop_c;

   logic signed [AW-1:0]  x_ext, y_ext;
   logic signed [AW-1:0]  avg_x, avg_y;
   logic                  z_unused;

   assign x_ext    = {{WINDOW_LOG2{acl_data[14]}}, acl_data[14:10]};
   assign y_ext    = {{WINDOW_LOG2{acl_data[9]}},  acl_data[9:5]};
   assign z_unused = ^acl_data[4:0];

   // Arithmetic shift floors toward minus infinity.
   assign avg_x = sum_x >>> WINDOW_LOG2;
   assign avg_y = sum_y >>> WINDOW_LOG2;

   assign code_out = {28'b0, throttle, steer};

   // Enter beats exit, so a strong opposite average switches sides directly.
   function automatic logic [1:0] hyst(input logic [1:0]        cur,
                                       input logic signed [AW-1:0] avg,
                                       input logic [1:0]        pos_code,
                                       input logic [1:0]        neg_code);
      logic [1:0] res;
      res = cur;
      if (avg >= ENTER_P)                          res = pos_code;
      else if (avg <= ENTER_N)                     res = neg_code;
      else if (cur == pos_code && avg <= EXIT_P)   res = 2'b00;
      else if (cur == neg_code && avg >= EXIT_N)   res = 2'b00;
      return res;
   endfunction

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ACCUM;
         sum_x       <= '0;
         sum_y       <= '0;
         cnt         <= '0;
         steer       <= 2'b00;
         throttle    <= 2'b00;
         out_valid   <= 1'b0;
         overrun_cnt <= 8'd0;
      end else begin
         state       <= state_nx;
         sum_x       <= sum_x_nx;
         sum_y       <= sum_y_nx;
         cnt         <= cnt_nx;
         steer       <= steer_nx;
         throttle    <= throttle_nx;
         out_valid   <= out_valid_nx;
         overrun_cnt <= overrun_nx;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_nx     = state;
      sum_x_nx     = sum_x;
      sum_y_nx     = sum_y;
      cnt_nx       = cnt;
      steer_nx     = steer;
      throttle_nx  = throttle;
      out_valid_nx = out_valid;
      drop_c       = 1'b0;

      case (state)
         ACCUM: begin
            if (sample_valid) begin
               sum_x_nx = sum_x + x_ext;
               sum_y_nx = sum_y + y_ext;
               cnt_nx   = cnt + CW'(1);
               if (cnt == LAST_CNT) state_nx = EVAL;
            end
         end
         EVAL: begin
            drop_c       = sample_valid;
            steer_nx     = hyst(steer, avg_x, STEER_RIGHT, STEER_LEFT);
            throttle_nx  = hyst(throttle, avg_y, THR_ACCEL, THR_BRAKE);
            sum_x_nx     = '0;
            sum_y_nx     = '0;
            cnt_nx       = '0;
            out_valid_nx = 1'b1;
            state_nx     = HOLD;
         end
         HOLD: begin
            // A strobe in the handshake cycle is dropped as well.
            drop_c = sample_valid;
            if (out_ready) begin
               out_valid_nx = 1'b0;
               state_nx     = ACCUM;
            end
         end
         default: state_nx = ACCUM;
      endcase

      overrun_nx = overrun_cnt;
      if (drop_c && overrun_cnt != 8'hFF) overrun_nx = overrun_cnt + 8'd1;
   end

endmodule

// File: tb/tb_accel_tilt_quantizer.sv
// Testbench for accel_tilt_quantizer: directed scenarios plus biased random
// stimulus, checked cycle by cycle against a window/queue reference model.
module tb_accel_tilt_quantizer;

   localparam int N     = 8;
   localparam int ENTER = 4;
   localparam int EXIT  = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        sample_valid = 1'b0;
   logic [14:0] acl_data = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] code_out;
   logic [7:0]  overrun_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: samples of the open window, pending evaluation,
   // pending output and the current decision.
   int q_x[$];
   int q_y[$];
   bit m_eval  = 0;
   bit m_valid = 0;
   int m_steer = 0;
   int m_thr   = 0;
   int m_ovf   = 0;

   accel_tilt_quantizer dut (
      .clock        (clock),
      .reset        (reset),
      .sample_valid (sample_valid),
      .acl_data     (acl_data),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .code_out     (code_out),
      .overrun_cnt  (overrun_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int floor_div(input int s, input int n);
      if (s >= 0) return s / n;
      return -((-s + n - 1) / n);
   endfunction

   function automatic int hyst(input int cur, input int avg, input int pos, input int neg);
      if (avg >= ENTER)              return pos;
      if (avg <= -ENTER)             return neg;
      if (cur == pos && avg <= EXIT) return 0;
      if (cur == neg && avg >= -EXIT) return 0;
      return cur;
   endfunction

   function automatic int m_code();
      return m_thr * 4 + m_steer;
   endfunction

   function automatic int clamp5(input int v);
      if (v > 15)  return 15;
      if (v < -16) return -16;
      return v;
   endfunction

   task automatic model_drop();
      if (m_ovf < 255) m_ovf++;
   endtask

   // One clock: check outputs, drive inputs, advance the model past the next edge.
   task automatic cycle(input bit sv, input int x, input int y, input bit rdy);
      int sx, sy;
      @(negedge clock);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("code_out", code_out, 32'(m_code()));
      check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovf));
      sample_valid = sv;
      acl_data     = {5'(x), 5'(y), 5'($urandom_range(0, 31))};
      out_ready    = rdy;
      if (m_valid) begin
         if (sv) model_drop();
         if (rdy) m_valid = 0;
      end else if (m_eval) begin
         if (sv) model_drop();
         sx = 0;
         sy = 0;
         foreach (q_x[i]) begin
            sx += q_x[i];
            sy += q_y[i];
         end
         m_steer = hyst(m_steer, floor_div(sx, N), 2, 1);
         m_thr   = hyst(m_thr,   floor_div(sy, N), 1, 2);
         q_x.delete();
         q_y.delete();
         m_eval  = 0;
         m_valid = 1;
      end else if (sv) begin
         q_x.push_back(x);
         q_y.push_back(y);
         if (q_x.size() == N) m_eval = 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   // Full window, X alternating x0/x1, constant Y.
   task automatic window(input int x0, input int x1, input int y);
      for (int i = 0; i < N; i++) cycle(1, (i % 2 == 0) ? x0 : x1, y, 0);
   endtask

   // Wait for the decision, check it against a literal, then accept it.
   task automatic consume(input string tag, input int exp);
      int budget = 6;
      while (!m_valid && budget > 0) begin
         cycle(0, 0, 0, 0);
         budget--;
      end
      if (!m_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
      cycle(0, 0, 0, 1);
      check(tag, code_out, 32'(exp));
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset        = 1'b1;
      sample_valid = 1'b0;
      out_ready    = 1'b0;
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_code_out", code_out, 32'd0);
      check("reset_overrun", 32'(overrun_cnt), 32'd0);
      q_x.delete();
      q_y.delete();
      m_eval  = 0;
      m_valid = 0;
      m_steer = 0;
      m_thr   = 0;
      m_ovf   = 0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int bias_x, bias_y;
      do_reset();

      // Right turn, then held output with out_ready low.
      window(6, 6, 0);
      idle(22);
      consume("right_hold", 32'h2);

      // Hysteresis walk on X starting from right.
      window(3, 3, 0);
      consume("hyst_x3_stays_right", 32'h2);
      window(2, 2, 0);
      consume("hyst_x2_center", 32'h0);
      window(-4, -4, 0);
      consume("hyst_xm4_left", 32'h1);
      window(4, 4, 0);
      consume("hyst_x4_direct_right", 32'h2);

      // Alternating X averages to zero, steady brake.
      window(7, -7, -5);
      consume("brake_center", 32'h8);
      // Y = -1 floors to -1, inside the exit band.
      window(0, 0, -1);
      consume("floor_coast", 32'h0);

      // Continuous strobes with no consumer: overrun saturates.
      for (int i = 0; i < 300; i++) cycle(1, $urandom_range(0, 6) - 3, 0, 0);
      cycle(0, 0, 0, 0);
      check("overrun_saturated", 32'(overrun_cnt), 32'd255);
      cycle(0, 0, 0, 1);

      // Strobe coincident with the handshake is dropped.
      do_reset();
      window(5, 5, 0);
      cycle(0, 0, 0, 0);
      cycle(1, 9, 9, 1);
      cycle(0, 0, 0, 0);
      check("handshake_strobe_dropped", 32'(overrun_cnt), 32'd1);

      // Reset mid-window discards the partial sum.
      for (int i = 0; i < 5; i++) cycle(1, 10, 10, 0);
      do_reset();
      idle(4);
      window(-8, -8, 0);
      idle(1);
      check("post_reset_no_valid_yet", 32'(out_valid), 32'd0);
      consume("post_reset_left", 32'h1);

      // Biased random traffic with occasional resets.
      bias_x = 0;
      bias_y = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 150 == 0) begin
            bias_x = int'($urandom_range(0, 24)) - 12;
            bias_y = int'($urandom_range(0, 24)) - 12;
         end
         if ($urandom_range(0, 599) == 0) do_reset();
         cycle($urandom_range(0, 9) < 6,
               clamp5(bias_x + int'($urandom_range(0, 8)) - 4),
               clamp5(bias_y + int'($urandom_range(0, 8)) - 4),
               $urandom_range(0, 1) == 1);
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
